// File: rtl/uart_tx_if.sv
// Read-side link from a first-word-fall-through FIFO to uart_tx.
// master: the transmitter that pops words. slave: the FIFO that supplies them.
interface uart_tx_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_data;
    logic                  fifo_ren;

    modport master (
        input  fifo_empty,
        input  fifo_data,
        output fifo_ren
    );

    modport slave (
        output fifo_empty,
        output fifo_data,
        input  fifo_ren
    );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter fed from a FWFT FIFO: start bit, DATA_WIDTH bits LSB first, stop bit.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data and stop bits.
module uart_tx #(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic      r_clk,
    input  logic      r_rst,
    uart_tx_if.master fifo,
    output logic      tx,
    output logic      tx_busy
);
    localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned BIT_W  = $clog2(DATA_WIDTH + 1);

    localparam logic [BAUD_W-1:0] BAUD_MAX = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(DATA_WIDTH - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;
`endif

    state_e                state_q, state_d;
    logic [BAUD_W-1:0]     baud_q, baud_d;
    logic [BIT_W-1:0]      bit_q, bit_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] shift_nxt;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;
    logic                  pop;
    logic                  baud_end;
`ifdef UART_TX_PARITY_EN
    logic                  parity_q, parity_d;
`endif

    // Pop strobe is combinational so the word is consumed in the cycle it is seen.
    assign pop           = (state_q == StIdle) && !fifo.fifo_empty && !r_rst;
    assign fifo.fifo_ren = pop;
    assign baud_end      = (baud_q == BAUD_MAX);
    assign shift_nxt     = shift_q >> 1;

    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        tx_d     = tx_q;
        busy_d   = busy_q;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (pop) begin
                    shift_d  = fifo.fifo_data;
                    baud_d   = '0;
                    bit_d    = '0;
                    tx_d     = 1'b0;
                    busy_d   = 1'b1;
                    state_d  = StStart;
`ifdef UART_TX_PARITY_EN
                    parity_d = ^fifo.fifo_data;
`endif
                end
            end
            StStart: begin
                if (baud_end) begin
                    baud_d  = '0;
                    tx_d    = shift_q[0];
                    state_d = StData;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            StData: begin
                if (baud_end) begin
                    baud_d  = '0;
                    shift_d = shift_nxt;
                    if (bit_q == BIT_LAST) begin
                        bit_d   = '0;
`ifdef UART_TX_PARITY_EN
                        tx_d    = parity_q;
                        state_d = StParity;
`else
                        tx_d    = 1'b1;
                        state_d = StStop;
`endif
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                        tx_d  = shift_nxt[0];
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            StParity: begin
                if (baud_end) begin
                    baud_d  = '0;
                    tx_d    = 1'b1;
                    state_d = StStop;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
`endif
            StStop: begin
                if (baud_end) begin
                    baud_d  = '0;
                    tx_d    = 1'b1;
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            default: begin
                state_d = StIdle;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge r_clk) begin
        if (r_rst) begin
            state_q  <= StIdle;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign tx      = tx_q;
    assign tx_busy = busy_q;
endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at CLKS_PER_BIT=4, DATA_WIDTH=8, with a queue-backed FWFT FIFO.
// Frames are decoded from a per-cycle log; expected frame words are hand-computed constants.
module tb_uart_tx;
    localparam int unsigned DW  = 8;
    localparam int unsigned CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int unsigned NB = 11;
    // Frame words: bit b = line level during frame bit b (start, data LSB first, parity, stop).
    localparam logic [31:0] EXP_A5 = 32'h54A;
    localparam logic [31:0] EXP_07 = 32'h60E;
    localparam logic [31:0] EXP_00 = 32'h400;
    localparam logic [31:0] EXP_FF = 32'h5FE;
    localparam logic [31:0] EXP_55 = 32'h4AA;
    localparam logic [31:0] EXP_96 = 32'h52C;
    localparam logic [31:0] EXP_5A = 32'h4B4;
`else
    localparam int unsigned NB = 10;
    localparam logic [31:0] EXP_A5 = 32'h34A;
    localparam logic [31:0] EXP_07 = 32'h20E;
    localparam logic [31:0] EXP_00 = 32'h200;
    localparam logic [31:0] EXP_FF = 32'h3FE;
    localparam logic [31:0] EXP_55 = 32'h2AA;
    localparam logic [31:0] EXP_96 = 32'h32C;
    localparam logic [31:0] EXP_5A = 32'h2B4;
`endif
    localparam int unsigned FL = 1 + NB * CPB;

    logic r_clk = 1'b0;
    logic r_rst;
    logic tx;
    logic tx_busy;

    uart_tx_if #(.DATA_WIDTH(DW)) fif ();

    uart_tx #(
        .DATA_WIDTH  (DW),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .r_clk  (r_clk),
        .r_rst  (r_rst),
        .fifo   (fif.master),
        .tx     (tx),
        .tx_busy(tx_busy)
    );

    always #5 r_clk = ~r_clk;

    logic [DW-1:0] fifo_q[$];
    logic          ren_log[$];
    logic          tx_log[$];
    logic          busy_log[$];
    int unsigned   pulse_q[$];
    int unsigned   cyc   = 0;
    int unsigned   n_cmp = 0;
    int unsigned   n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive_fifo();
        fif.fifo_empty = (fifo_q.size() == 0);
        fif.fifo_data  = (fifo_q.size() != 0) ? fifo_q[0] : 8'h3C;
    endtask

    // One log entry per cycle, sampled on the falling edge; the FIFO pops on the rising edge.
    task automatic run(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            logic popped;
            @(negedge r_clk);
            ren_log.push_back(fif.fifo_ren);
            tx_log.push_back(tx);
            busy_log.push_back(tx_busy);
            popped = fif.fifo_ren;
            @(posedge r_clk);
            #1;
            cyc++;
            if (popped === 1'b1 && fifo_q.size() != 0) void'(fifo_q.pop_front());
            drive_fifo();
        end
    endtask

    task automatic find_pulses(input int unsigned lo);
        pulse_q = {};
        for (int unsigned i = lo; i < cyc; i++) if (ren_log[i] === 1'b1) pulse_q.push_back(i);
    endtask

    function automatic logic [31:0] frame_at(input int unsigned p);
        logic [31:0] f = '0;
        for (int unsigned b = 0; b < NB; b++) f[b] = tx_log[p + 1 + b * CPB + CPB / 2];
        return f;
    endfunction

    function automatic int unsigned glitches(input int unsigned p);
        int unsigned g = 0;
        for (int unsigned b = 0; b < NB; b++)
            for (int unsigned j = 0; j < CPB; j++)
                if (tx_log[p + 1 + b * CPB + j] !== tx_log[p + 1 + b * CPB + CPB / 2]) g++;
        return g;
    endfunction

    function automatic int unsigned count_hi(input logic q[$], input int unsigned lo,
                                             input int unsigned n);
        int unsigned c = 0;
        for (int unsigned i = lo; i < lo + n; i++) if (q[i] === 1'b1) c++;
        return c;
    endfunction

    initial begin
        int unsigned p;
        int unsigned r;

        r_rst = 1'b1;
        drive_fifo();
        run(3);
        check_eq("rst_ren", 32'(ren_log[2]), 32'd0);
        check_eq("rst_tx", 32'(tx_log[2]), 32'd1);
        check_eq("rst_busy", 32'(busy_log[2]), 32'd0);

        // Reset release and first word arrive together.
        r_rst = 1'b0;
        fifo_q.push_back(8'hA5);
        drive_fifo();
        p = cyc;
        run(FL + 3);
        check_eq("a5_ren_first", 32'(ren_log[p]), 32'd1);
        check_eq("a5_tx_fall", 32'(tx_log[p + 1]), 32'd0);
        check_eq("a5_busy_rise", 32'(busy_log[p + 1]), 32'd1);
        find_pulses(p);
        check_eq("a5_pops", pulse_q.size(), 32'd1);
        check_eq("a5_frame", frame_at(p), EXP_A5);
        check_eq("a5_glitch", glitches(p), 32'd0);
        check_eq("a5_busy_cycles", count_hi(busy_log, p, FL + 3), NB * CPB);

        p = cyc;
        run(100);
        check_eq("idle_ren", count_hi(ren_log, p, 100), 32'd0);
        check_eq("idle_tx", count_hi(tx_log, p, 100), 32'd100);
        check_eq("idle_busy", count_hi(busy_log, p, 100), 32'd0);

        p = cyc;
        fifo_q.push_back(8'hA5);
        fifo_q.push_back(8'h07);
        drive_fifo();
        run(2 * FL + 3);
        find_pulses(p);
        check_eq("pair_pops", pulse_q.size(), 32'd2);
        if (pulse_q.size() == 2) check_eq("pair_gap", pulse_q[1] - pulse_q[0], FL);
        check_eq("pair_a5", frame_at(p), EXP_A5);
        check_eq("pair_07", frame_at(p + FL), EXP_07);

        p = cyc;
        fifo_q.push_back(8'h00);
        fifo_q.push_back(8'hFF);
        fifo_q.push_back(8'h55);
        drive_fifo();
        run(3 * FL + 3);
        find_pulses(p);
        check_eq("tri_pops", pulse_q.size(), 32'd3);
        if (pulse_q.size() == 3) begin
            check_eq("tri_gap0", pulse_q[1] - pulse_q[0], FL);
            check_eq("tri_gap1", pulse_q[2] - pulse_q[1], FL);
        end
        check_eq("tri_00", frame_at(p), EXP_00);
        check_eq("tri_ff", frame_at(p + FL), EXP_FF);
        check_eq("tri_55", frame_at(p + 2 * FL), EXP_55);
        check_eq("tri_glitch", glitches(p + FL), 32'd0);

        // One-cycle reset while data bit 3 of 0xC3 is on the line.
        p = cyc;
        fifo_q.push_back(8'hC3);
        fifo_q.push_back(8'h96);
        drive_fifo();
        run(4 * CPB + 2);
        r = cyc;
        r_rst = 1'b1;
        run(1);
        r_rst = 1'b0;
        run(FL + 3);
        check_eq("mid_bit3", 32'(tx_log[r]), 32'd0);
        check_eq("mid_ren_rst", 32'(ren_log[r]), 32'd0);
        check_eq("mid_tx_after", 32'(tx_log[r + 1]), 32'd1);
        check_eq("mid_busy_after", 32'(busy_log[r + 1]), 32'd0);
        check_eq("mid_ren_after", 32'(ren_log[r + 1]), 32'd1);
        check_eq("mid_96", frame_at(r + 1), EXP_96);
        find_pulses(p);
        check_eq("mid_pops", pulse_q.size(), 32'd2);
        check_eq("mid_fifo_left", fifo_q.size(), 32'd0);

        // Data waiting while reset is held must not be popped until release.
        r_rst = 1'b1;
        fifo_q.push_back(8'h5A);
        drive_fifo();
        p = cyc;
        run(3);
        check_eq("hold_ren", count_hi(ren_log, p, 3), 32'd0);
        r_rst = 1'b0;
        p = cyc;
        run(FL + 3);
        check_eq("hold_ren_first", 32'(ren_log[p]), 32'd1);
        check_eq("hold_5a", frame_at(p), EXP_5A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
